// File: rtl/mux7_rr_scheduler_pkg.sv
// Shared definitions for the 7-way round-robin select scheduler:
// state encoding, sizes, the idle select code and the rotating index helper.
package mux7_rr_scheduler_pkg;

  localparam int N_INPUTS = 7;
  localparam int CNT_W    = 4;
  localparam logic [2:0] IDLE_SEL_DEFAULT = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Index reached by stepping k positions past base, wrapping modulo N_INPUTS.
  function automatic logic [2:0] rot_idx(input logic [2:0] base, input int k);
    int s;
    s = (int'(base) + k) % N_INPUTS;
    return 3'(s);
  endfunction

endpackage

// File: rtl/mux7_rr_scheduler_rr_pick7.sv
// Combinational rotating-priority picker: first set request after 'last',
// with 'last' itself scanned at the very end.
module rr_pick7
  import mux7_rr_scheduler_pkg::*;
(
  input  logic [6:0] req,
  input  logic [2:0] last,
  output logic [2:0] pick,
  output logic       found
);

  // Walk from the farthest position to the nearest so the nearest hit wins.
  always_comb begin
    pick  = 3'd0;
    found = 1'b0;
    for (int k = N_INPUTS; k >= 1; k--) begin
      if (req[rot_idx(last, k)]) begin
        pick  = rot_idx(last, k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux7_rr_scheduler.sv
// Round-robin owner of a 7:1 one-bit select path: arbitrates requests,
// bounds each tenure with a dwell counter and registers the selected bit.
module mux7_rr_scheduler
  import mux7_rr_scheduler_pkg::*;
#(
  parameter int         DWELL    = 4,
  parameter logic [2:0] IDLE_SEL = IDLE_SEL_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [6:0] req,
  input  logic [6:0] data,
  output logic [2:0] mux_select,
  output logic [6:0] grant,
  output logic       busy,
  output logic       out,
  output logic       out_valid
);

  state_t           state_reg, state_next;
  logic [2:0]       mux_select_reg, mux_select_next;
  logic [6:0]       grant_reg, grant_next;
  logic             busy_reg, busy_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       last_reg, last_next;
  logic             out_reg, out_next;
  logic             out_valid_reg, out_valid_next;

  logic [2:0] pick_last;
  logic [2:0] pick;
  logic       found;
  logic       hold_continue;

  // A releasing holder becomes the new 'last' on the same edge it re-picks.
  assign pick_last = (state_reg == HOLD) ? mux_select_reg : last_reg;

  rr_pick7 u_pick (
    .req   (req),
    .last  (pick_last),
    .pick  (pick),
    .found (found)
  );

  assign hold_continue = (state_reg == HOLD) && enable &&
                         req[mux_select_reg] && (cnt_reg != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    if (hold_continue || (enable && found)) begin
      state_next = HOLD;
    end
  end

  always_comb begin
    mux_select_next = IDLE_SEL;
    grant_next      = '0;
    busy_next       = 1'b0;
    cnt_next        = '0;
    last_next       = last_reg;
    if (hold_continue) begin
      mux_select_next = mux_select_reg;
      grant_next      = grant_reg;
      busy_next       = 1'b1;
      cnt_next        = cnt_reg - 1'b1;
    end else if (enable && found) begin
      mux_select_next = pick;
      grant_next      = 7'b1 << pick;
      busy_next       = 1'b1;
      cnt_next        = CNT_W'(DWELL - 1);
    end
    if ((state_reg == HOLD) && !hold_continue) begin
      last_next = mux_select_reg;
    end
    out_next       = busy_reg ? data[mux_select_reg] : out_reg;
    out_valid_next = busy_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_select_reg <= IDLE_SEL;
      grant_reg      <= '0;
      busy_reg       <= 1'b0;
      cnt_reg        <= '0;
      last_reg       <= 3'd6;
      out_reg        <= 1'b0;
      out_valid_reg  <= 1'b0;
    end else begin
      mux_select_reg <= mux_select_next;
      grant_reg      <= grant_next;
      busy_reg       <= busy_next;
      cnt_reg        <= cnt_next;
      last_reg       <= last_next;
      out_reg        <= out_next;
      out_valid_reg  <= out_valid_next;
    end
  end

  assign mux_select = mux_select_reg;
  assign grant      = grant_reg;
  assign busy       = busy_reg;
  assign out        = out_reg;
  assign out_valid  = out_valid_reg;

endmodule

// File: tb/tb_mux7_rr_scheduler.sv
// Scoreboard bench for mux7_rr_scheduler: an owner/tenure reference model
// queues expected outputs per edge; a monitor pops and compares them.
module tb_mux7_rr_scheduler;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [6:0] req;
  logic [6:0] data;
  logic [2:0] mux_select;
  logic [6:0] grant;
  logic       busy;
  logic       out;
  logic       out_valid;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [2:0] sel;
    logic [6:0] gnt;
    logic       busy;
    logic       out;
    logic       ov;
  } exp_t;

  exp_t exp_q[$];

  mux7_rr_scheduler #(.DWELL(DWELL), .IDLE_SEL(3'b111)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .req        (req),
    .data       (data),
    .mux_select (mux_select),
    .grant      (grant),
    .busy       (busy),
    .out        (out),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the path, how long they've had it, who went last.
  int   m_owner;
  int   m_used;
  int   m_last;
  logic m_out;
  logic m_ov;

  function automatic int ref_pick(input logic [6:0] r, input int last);
    for (int k = 1; k <= 7; k++) begin
      int i;
      i = (last + k) % 7;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    exp_t e;
    int   prev_owner;
    prev_owner = m_owner;
    if (prev_owner >= 0) m_out = data[prev_owner];
    m_ov = (prev_owner >= 0);
    if (m_owner < 0) begin
      if (enable) begin
        m_owner = ref_pick(req, m_last);
        m_used  = 1;
      end
    end else if (!enable) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (req[m_owner] && m_used < DWELL) begin
      m_used++;
    end else begin
      m_last  = m_owner;
      m_owner = ref_pick(req, m_last);
      m_used  = 1;
    end
    e.sel  = (m_owner < 0) ? 3'b111 : 3'(m_owner);
    e.gnt  = (m_owner < 0) ? 7'b0 : (7'b1 << m_owner);
    e.busy = (m_owner >= 0);
    e.out  = m_out;
    e.ov   = m_ov;
    exp_q.push_back(e);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_used  = 0;
      m_last  = 6;
      m_out   = 1'b0;
      m_ov    = 1'b0;
      exp_q.delete();
    end else begin
      model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: on each edge compare against the queued expectation; on a
  // reset assertion check the outputs collapse without waiting for a clock.
  initial begin
    exp_t e;
    int   txn;
    txn = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        chk("rst_sel",   32'(mux_select), 32'd7);
        chk("rst_grant", 32'(grant),      32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_out",   32'(out),        32'd0);
        chk("rst_ov",    32'(out_valid),  32'd0);
        $display("[%0t] async reset observed", $time);
      end else begin
        #1;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          txn++;
          chk("sel",   32'(mux_select), 32'(e.sel));
          chk("grant", 32'(grant),      32'(e.gnt));
          chk("busy",  32'(busy),       32'(e.busy));
          chk("ov",    32'(out_valid),  32'(e.ov));
          chk("out",   32'(out),        32'(e.out));
          $display("[%0t] txn %0d req=%b en=%b sel=%0d grant=%b busy=%b out=%b ov=%b",
                   $time, txn, req, enable, mux_select, grant, busy, out, out_valid);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      data = 7'($urandom);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    req    = 7'b0;
    data   = 7'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // First grant and out path latency
    enable = 1'b1;
    req    = 7'b0000001;
    step(4);
    req = 7'b0;
    step(2);

    // All requesting: full rotation at DWELL cycles each
    req = 7'h7f;
    step(32);
    req = 7'b0;
    step(2);

    // Lone requester keeps the grant across dwell reloads
    req = 7'b0001000;
    step(10);
    req = 7'b0;
    step(2);

    // Holder drops while another waits
    req = 7'b0000100;
    step(1);
    req = 7'b0100100;
    step(2);
    req = 7'b0100000;
    step(3);
    req = 7'b0;
    step(2);

    // Enable removed mid-tenure on index 4, then everyone asks
    req = 7'b0010000;
    step(2);
    enable = 1'b0;
    step(2);
    req    = 7'h7f;
    enable = 1'b1;
    step(3);

    // Randomized traffic
    repeat (400) begin
      req    = 7'($urandom) & 7'($urandom);
      enable = ($urandom_range(0, 15) != 0);
      step(1);
    end

    // Asynchronous reset mid-tenure, between edges
    req    = 7'h7f;
    enable = 1'b1;
    step(3);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(10);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
